// File: rtl/iob_gpio_ssd.sv
// Multiplexed seven-segment scanner on the IOb native bus.
// CPU writes a staging copy of the digits; it is latched into the active copy at each frame wrap.
module iob_gpio_ssd #(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 3,
   parameter int N_DIGITS        = 8,
   parameter int PRESC_W         = 16,
   parameter int GUARD_CYCLES    = 4,
   parameter int ANODE_ACT_LOW   = 1,
   parameter int CATHODE_ACT_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ready,
   output logic [N_DIGITS-1:0]   anode_output,
   output logic [7:0]            cathode_output,
   output logic                  frame_irq
);

   localparam logic [7:0]        DIG_MSK  = 8'((1 << N_DIGITS) - 1);
   localparam logic              AN_INV   = (ANODE_ACT_LOW != 0);
   localparam logic              CA_INV   = (CATHODE_ACT_LOW != 0);
   localparam logic [2:0]        LAST_IDX = 3'(N_DIGITS - 1);
   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_DLO    = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_DHI    = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(5);

   typedef enum logic [1:0] {S_OFF, S_ON, S_GUARD} state_t;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [DATA_W/8-1:0] strb);
      merge_bytes = old_v;
      for (int b = 0; b < DATA_W/8; b++)
         if (strb[b]) merge_bytes[b*8 +: 8] = new_v[b*8 +: 8];
   endfunction

   logic                 en, hex, frame_done;
   logic [PRESC_W-1:0]   presc;
   logic [7:0][7:0]      dig_stg, dig_act, dig_rd;
   logic [7:0]           dp_stg, blank_stg, dp_act, blank_act;

   state_t               state, state_n;
   logic [PRESC_W-1:0]   cnt, cnt_n;
   logic [2:0]           idx, idx_n;
   logic                 load, wrap;

   logic                 acc, wr_en, rd_en;
   logic [DATA_W-1:0]    rd_val, wr_val;
   logic [N_DIGITS-1:0]  an_log;
   logic [7:0]           seg_log, cur_byte;

   assign acc    = valid & ~ready;
   assign wr_en  = acc & (|wstrb);
   assign rd_en  = acc & ~(|wstrb);
   assign wr_val = merge_bytes(rd_val, wdata, wstrb);

   always_comb begin
      for (int i = 0; i < 8; i++) dig_rd[i] = DIG_MSK[i] ? dig_stg[i] : 8'h00;
   end

   // Read view doubles as the base for byte-merged writes.
   always_comb begin
      rd_val = '0;
      case (address)
         A_CTRL:  rd_val[1:0]         = {hex, en};
         A_PRESC: rd_val[PRESC_W-1:0] = presc;
         A_DLO:   rd_val[31:0]        = dig_rd[3:0];
         A_DHI:   rd_val[31:0]        = dig_rd[7:4];
         A_MASK:  rd_val[15:0]        = {blank_stg & DIG_MSK, dp_stg & DIG_MSK};
         A_STAT:  begin
            rd_val[0]    = frame_done;
            rd_val[10:8] = idx;
         end
         default: rd_val = '0;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      load    = 1'b0;
      wrap    = 1'b0;
      case (state)
         S_OFF: begin
            idx_n = '0;
            if (en) begin
               state_n = S_ON;
               cnt_n   = presc;
               load    = 1'b1;
            end
         end
         S_ON: begin
            if (cnt == '0) begin
               state_n = S_GUARD;
               cnt_n   = PRESC_W'(GUARD_CYCLES - 1);
            end else cnt_n = cnt - 1'b1;
         end
         default: begin
            if (cnt == '0) begin
               state_n = S_ON;
               cnt_n   = presc;
               if (idx == LAST_IDX) begin
                  idx_n = '0;
                  wrap  = 1'b1;
                  load  = 1'b1;
               end else idx_n = idx + 1'b1;
            end else cnt_n = cnt - 1'b1;
         end
      endcase
      // Disable overrides everything, including a wrap due this cycle.
      if (!en) begin
         state_n = S_OFF;
         idx_n   = '0;
         load    = 1'b0;
         wrap    = 1'b0;
      end
   end

   always_comb begin
      an_log   = '0;
      seg_log  = '0;
      cur_byte = dig_act[idx];
      if (state == S_ON) begin
         an_log = N_DIGITS'(1) << idx;
         if (!blank_act[idx])
            seg_log = hex ? {dp_act[idx], hex7(cur_byte[3:0])} : (cur_byte | {dp_act[idx], 7'b0});
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_OFF;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ready          <= 1'b0;
         rdata          <= '0;
         frame_irq      <= 1'b0;
         en             <= 1'b0;
         hex            <= 1'b0;
         presc          <= PRESC_W'(999);
         dig_stg        <= '0;
         dig_act        <= '0;
         dp_stg         <= '0;
         blank_stg      <= '0;
         dp_act         <= '0;
         blank_act      <= '0;
         frame_done     <= 1'b0;
         anode_output   <= {N_DIGITS{AN_INV}};
         cathode_output <= {8{CA_INV}};
      end else begin
         ready     <= acc;
         rdata     <= rd_en ? rd_val : '0;
         frame_irq <= wrap;
         if (wr_en) begin
            case (address)
               A_CTRL:  {hex, en}        <= wr_val[1:0];
               A_PRESC: presc            <= wr_val[PRESC_W-1:0];
               A_DLO:   dig_stg[3:0]     <= wr_val[31:0];
               A_DHI:   dig_stg[7:4]     <= wr_val[31:0];
               A_MASK:  {blank_stg, dp_stg} <= wr_val[15:0];
               default: ;
            endcase
         end
         // A wrap in the same cycle as a clear keeps the flag set.
         if (wrap) frame_done <= 1'b1;
         else if (wr_en && address == A_STAT && wstrb[0] && wdata[0]) frame_done <= 1'b0;
         if (load) begin
            dig_act   <= dig_stg;
            dp_act    <= dp_stg;
            blank_act <= blank_stg;
         end
         anode_output   <= an_log ^ {N_DIGITS{AN_INV}};
         cathode_output <= seg_log ^ {8{CA_INV}};
      end
   end

endmodule

// File: tb/tb_iob_gpio_ssd.sv
// Scoreboard bench for iob_gpio_ssd: a frame-position model predicts the pins every cycle,
// bus reads are predicted from a register model; a monitor process compares both.
module tb_iob_gpio_ssd;
   localparam int N = 8;
   localparam int G = 4;

   logic        clk = 1'b0, rst = 1'b0, valid = 1'b0;
   logic [2:0]  address = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic [31:0] rdata;
   logic        ready, frame_irq;
   logic [7:0]  anode_output, cathode_output;

   always #5 clk = ~clk;

   iob_gpio_ssd dut (
      .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
      .rdata(rdata), .ready(ready), .anode_output(anode_output),
      .cathode_output(cathode_output), .frame_irq(frame_irq));

   int errors = 0, checks = 0;

   typedef struct {bit chk; logic [31:0] exp; logic [31:0] msk; string name;} bus_t;
   typedef struct {logic [7:0] an; logic [7:0] ca; logic irq; int k;} pin_t;
   bus_t bus_q[$];
   pin_t pin_q[$];

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model state
   bit          m_en = 0, m_hex = 0, m_fd = 0;
   logic [15:0] m_presc = 16'd999;
   logic [7:0]  stg [8], act [8];
   logic [7:0]  s_dp = '0, s_bl = '0, a_dp = '0, a_bl = '0;
   bit          run = 0, load_pend = 0, dis_pend = 0, wrap_now = 0, mdl_on = 0;
   int          k = 0, L = 8;

   initial for (int i = 0; i < 8; i++) begin stg[i] = '0; act[i] = '0; end

   function automatic logic [7:0] seg_exp(input int d);
      if (a_bl[d]) return 8'h00;
      if (m_hex)   return {a_dp[d], hex_tab[act[d][3:0]]};
      return act[d] | {a_dp[d], 7'b0};
   endfunction

   // k counts edges since the enabling write was accepted; pins follow from frame position.
   task automatic model_step();
      pin_t p;
      int pos, d;
      wrap_now = 0;
      p.an = 8'hFF; p.ca = 8'hFF; p.irq = 1'b0;
      if (run) begin
         k++;
         if (load_pend) begin
            for (int i = 0; i < 8; i++) act[i] = stg[i];
            a_dp = s_dp; a_bl = s_bl; load_pend = 0;
         end
         if (!dis_pend && k > 1 && (k - 1) % (N * L) == 0) begin
            p.irq = 1'b1; wrap_now = 1; m_fd = 1;
            for (int i = 0; i < 8; i++) act[i] = stg[i];
            a_dp = s_dp; a_bl = s_bl;
         end
         if (k >= 2) begin
            pos = k - 2;
            d   = (pos / L) % N;
            if (pos % L <= int'(m_presc)) begin
               p.an = ~(8'h01 << d);
               p.ca = ~seg_exp(d);
            end
         end
         if (dis_pend) begin run = 0; dis_pend = 0; end
      end
      p.k = k;
      pin_q.push_back(p);
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return {30'b0, m_hex, m_en};
         3'd1: return {16'b0, m_presc};
         3'd2: return {stg[3], stg[2], stg[1], stg[0]};
         3'd3: return {stg[7], stg[6], stg[5], stg[4]};
         3'd4: return {16'b0, s_bl, s_dp};
         3'd5: return {31'b0, m_fd};
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] v;
      v = m_read(a);
      for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
      case (a)
         3'd0: begin
            if (v[0] && !m_en) begin
               run = 1; k = 0; load_pend = 1; dis_pend = 0; L = int'(m_presc) + 1 + G;
            end else if (!v[0] && m_en) dis_pend = run;
            m_en = v[0]; m_hex = v[1];
         end
         3'd1: m_presc = v[15:0];
         3'd2: for (int i = 0; i < 4; i++) stg[i] = v[i*8 +: 8];
         3'd3: for (int i = 0; i < 4; i++) stg[i+4] = v[i*8 +: 8];
         3'd4: begin s_dp = v[7:0]; s_bl = v[15:8]; end
         3'd5: if (s[0] && d[0] && !wrap_now) m_fd = 0;
         default: ;
      endcase
   endtask

   task automatic tick();
      @(posedge clk); #1;
      if (mdl_on) model_step();
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_op(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit is_rd, input logic [31:0] msk, input string nm);
      bus_t b;
      int n;
      if (ready) tick();
      b.chk = is_rd; b.exp = m_read(a) & msk; b.msk = msk; b.name = nm;
      bus_q.push_back(b);
      address = a; wdata = d; wstrb = is_rd ? 4'h0 : s; valid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!ready && n < 8);
      valid = 1'b0; wstrb = 4'h0;
      if (!ready) begin
         checks++; errors++;
         $display("FAIL bus_timeout %s: no ready after %0d cycles", nm, n);
         void'(bus_q.pop_back());
      end else if (!is_rd) m_write(a, d, s);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
      bus_op(a, d, s, 1'b0, 32'h0, "write");
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] msk, input string nm);
      bus_op(a, 32'h0, 4'h0, 1'b1, msk, nm);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Wait (bounded) until the model reaches a frame position where cond holds.
   task automatic wait_digit_on(input int dig);
      int n = 0;
      while (!(run && k >= 2 && ((k - 2) % (N * L)) / L == dig && (k - 2) % L <= int'(m_presc))
             && n < 400) begin tick(); n++; end
      if (n >= 400) chk("wait_digit_timeout", 32'(n), 32'd0);
   endtask

   task automatic wait_pre_wrap();
      int n = 0;
      while (!(run && k > 0 && k % (N * L) == 0) && n < 400) begin tick(); n++; end
      if (n >= 400) chk("wait_wrap_timeout", 32'(n), 32'd0);
   endtask

   // Monitor: compares after the stimulus/model step of each edge.
   always @(posedge clk) begin
      pin_t p;
      bus_t b;
      #2;
      if (mdl_on) begin
         if (pin_q.size() > 0) begin
            p = pin_q.pop_front();
            checks++;
            if ({anode_output, cathode_output, frame_irq} !== {p.an, p.ca, p.irq}) begin
               errors++;
               $display("FAIL pins k=%0d: got an=%h ca=%h irq=%b expected an=%h ca=%h irq=%b",
                        p.k, anode_output, cathode_output, frame_irq, p.an, p.ca, p.irq);
            end
         end
         if (ready) begin
            if (bus_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ready: got ready=1 expected no pending request");
            end else begin
               b = bus_q.pop_front();
               if (b.chk) begin
                  checks++;
                  if ((rdata & b.msk) !== b.exp) begin
                     errors++;
                     $display("FAIL read %s: got %h expected %h", b.name, rdata & b.msk, b.exp);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      run_n(3);
      chk("reset_anode", {24'b0, anode_output}, 32'hFF);
      chk("reset_cathode", {24'b0, cathode_output}, 32'hFF);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_ready_irq", {30'b0, ready, frame_irq}, 32'h0);
      rst = 1'b1;
      mdl_on = 1;
      run_n(2);
      rd(3'd5, 32'h0000_07FF, "status_reset");
      rd(3'd1, 32'hFFFF_FFFF, "presc_reset");
      rd(3'd0, 32'hFFFF_FFFF, "ctrl_reset");
      rd(3'd4, 32'hFFFF_FFFF, "mask_reset");
      rd(3'd6, 32'hFFFF_FFFF, "unmapped");

      // Hex scan
      wr(3'd1, 32'd3, 4'hF);
      wr(3'd2, 32'h0302_0100, 4'hF);
      wr(3'd3, 32'h0706_0504, 4'hF);
      rd(3'd3, 32'hFFFF_FFFF, "dig_hi");
      wr(3'd0, 32'h3, 4'h1);
      run_n(140);

      // Tear-free staging update mid-frame
      wait_digit_on(2);
      wr(3'd2, 32'h0000_000F, 4'hF);
      run_n(2 * N * L);

      // FRAME_DONE set, clear, clear coincident with wrap
      rd(3'd5, 32'h1, "frame_done_set");
      wr(3'd5, 32'h1, 4'h1);
      rd(3'd5, 32'h1, "frame_done_clr");
      wait_pre_wrap();
      wr(3'd5, 32'h1, 4'h1);
      rd(3'd5, 32'h1, "frame_done_set_wins");

      // Blank digit 1, DP on digit 0
      wr(3'd4, 32'h0000_0201, 4'h3);
      run_n(2 * N * L);

      // Disable during digit 3 then re-enable
      wait_digit_on(3);
      wr(3'd0, 32'h2, 4'h1);
      run_n(6);
      rd(3'd5, 32'h0000_0700, "idx_after_off");
      wr(3'd0, 32'h3, 4'h1);
      run_n(N * L + 10);

      // Randomized configurations
      for (int it = 0; it < 5; it++) begin
         wr(3'd0, 32'h0, 4'h1);
         run_n(3);
         wr(3'd1, 32'($urandom_range(0, 3)), 4'h3);
         wr(3'd2, $urandom, 4'($urandom_range(1, 15)));
         wr(3'd3, $urandom, 4'hF);
         wr(3'd4, $urandom & 32'hFFFF, 4'h3);
         rd(3'd2, 32'hFFFF_FFFF, "rand_dig_lo");
         rd(3'd4, 32'hFFFF_FFFF, "rand_mask");
         rd(3'd1, 32'hFFFF_FFFF, "rand_presc");
         wr(3'd0, {30'b0, 1'($urandom_range(0, 1)), 1'b1}, 4'h1);
         run_n($urandom_range(10, 40));
         wr(3'd3, $urandom, 4'($urandom_range(1, 15)));
         run_n(2 * N * L + 5);
      end

      run_n(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iob_gpio_ssd.md
# iob_gpio_ssd

Multiplexed seven-segment display controller that extends the GPIO cathode/anode outputs into a self-refreshing scanner. The CPU writes digit contents once. The block then time-multiplexes up to 8 digits onto a shared 8-bit cathode bus and a one-hot anode bus. It supports a programmable refresh rate, hex decode, per-digit blanking and decimal points, anti-ghosting guard intervals, tear-free frame updates, and a frame interrupt. It sits on the IOb native slave bus beside iob_gpio and drives display pins directly.

## Interface
Parameters:
- DATA_W, 32, CPU data width
- ADDR_W, 3, word-address width
- N_DIGITS, 8, number of digits scanned (1..8)
- PRESC_W, 16, refresh prescaler width
- GUARD_CYCLES, 4, all-off cycles between digits (≥1)
- ANODE_ACT_LOW, 1, anode_output active level is 0 when 1
- CATHODE_ACT_LOW, 1, cathode_output active level is 0 when 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset: sampled on the clk rising edge; 0 resets
- valid  in  1  bus request
- address  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte write strobes; all-zero means read
- rdata  out  DATA_W  read data, valid while ready=1
- ready  out  1  one-cycle acknowledge
- anode_output  out  N_DIGITS  digit select, one-hot when active
- cathode_output  out  8  segments: a=bit0 … g=bit6, dp=bit7
- frame_irq  out  1  one-cycle pulse at each frame wrap

## Operation
Registers, by word address:
- 0 CTRL: bit0 EN, bit1 HEX. Reset value 0.
- 1 PRESC: digit-on time = PRESC+1 cycles. Reset value 999.
- 2 DIG_LO: bytes hold digits 0..3.
- 3 DIG_HI: bytes hold digits 4..7.
- 4 MASK: bits[7:0] DP enable, bits[15:8] BLANK. Reset value 0.
- 5 STATUS: bit0 FRAME_DONE (sticky, write-1-to-clear), bits[10:8] current digit index, read-only.
- Unmapped reads return 0. Unmapped writes are ignored. Bits above N_DIGITS read 0.

Register writes:
- Every write is byte-granular per wstrb.
- DIG_*/MASK writes go to a staging copy.
- The staging copy is transferred to the active copy on every frame wrap, and when EN goes 0→1.

Segment pattern for digit i, from the active copy:
- HEX=1: the low nibble of the byte is decoded:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
  - Bit7 is then set from DP[i].
- HEX=0: the raw byte is used, ORed with DP[i]<<7.
- BLANK[i]=1: segments are forced to 0 and the anode still cycles, so timing stays uniform.

FSM, with counter cnt (PRESC_W bits) and index idx:
- OFF:
  - All outputs inactive; idx=0.
  - EN=1 → ON: load the active copy, cnt=PRESC.
- ON:
  - Anode idx active; cathodes show the pattern for idx.
  - cnt decrements each cycle.
  - cnt==0 → GUARD with cnt=GUARD_CYCLES-1.
- GUARD:
  - All outputs inactive.
  - cnt==0 → ON with cnt=PRESC, idx advanced.
  - If idx==N_DIGITS-1: idx wraps to 0, the active copy reloads, FRAME_DONE←1, frame_irq pulses for one cycle.
- Any state with EN=0 → OFF on the next cycle.
- Logical levels are XORed with the ACT_LOW parameters at the registered outputs.

## Timing
- Reset (rst=0 at an edge):
  - ready=0, rdata=0, frame_irq=0.
  - FSM=OFF; all registers at their reset values.
  - anode_output = all-inactive ({N_DIGITS{ANODE_ACT_LOW}}).
  - cathode_output = {8{CATHODE_ACT_LOW}}.
  - Reset mid-scan takes effect at that edge; no partial frame completes.
- Bus:
  - A request accepted at edge t gives ready=1 and rdata valid for edge t+1 only.
  - valid must be held until ready.
  - Back-to-back requests are allowed every 2 cycles.
  - Write data is visible to reads at t+1.
- A CTRL.EN write acknowledged at t: FSM is in ON after t+1; digit 0 pins are active after t+2. Outputs are registered with 1-cycle latency.
- Frame period = N_DIGITS·(PRESC+1+GUARD_CYCLES) cycles.
- frame_irq asserts on the same cycle FRAME_DONE sets.
- A CPU write-1-to-clear on FRAME_DONE in the same cycle as a wrap leaves FRAME_DONE=1 (set wins).
- A staging write coincident with a wrap lands in staging and becomes active at the next wrap.
- PRESC=0 gives 1-cycle digit-on time. A PRESC change takes effect at the next cnt reload.

## Test plan
- Reset: hold rst=0 for 3 cycles, release → anode_output=FF, cathode_output=FF, rdata=0, STATUS=0, PRESC reads 999.
- Hex scan:
  - Setup: PRESC=3, GUARD_CYCLES=4, HEX=1, DIG_LO=0x03020100, DIG_HI=0x07060504, EN=1.
  - Required: cathodes (active-low) show ~3F, ~06, ~5B … ~07 on anodes FE, FD … 7F.
  - Each digit is on 4 cycles, with 4 all-off cycles between digits.
  - frame_irq fires every 64 cycles.
- Tear-free update: mid-frame, write DIG_LO=0x0F → digit 0 still shows 3F until the wrap, then 71.
- Blank/DP: MASK=0x0201 → digit 0 shows pattern|0x80; digit 1 cathodes are all inactive while its anode still asserts.
- FRAME_DONE: after a wrap, STATUS bit0=1; writing 1 clears it; a clear coincident with a wrap leaves 1.
- Disable mid-scan: write EN=0 during digit 3 → all outputs inactive within 2 cycles; re-enable restarts at digit 0.
